// File: rtl/flash_pkg.sv
// Shared definitions for the flash prefetch line buffer.
// Holds the controller state encoding, the default line size and helpers that
// derive the word-index and tag widths from a line size.
package flash_pkg;

  localparam int ADDR_W             = 24;
  localparam int DATA_W             = 32;
  localparam int LINE_WORDS_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_START = 2'd2,
    ST_FILL  = 2'd3
  } state_e;

  // Bits needed to select one word inside a line.
  function automatic int idx_width(input int line_words);
    return $clog2(line_words);
  endfunction

  // Address bits above the word index and the byte offset.
  function automatic int tag_width(input int line_words);
    return ADDR_W - 2 - idx_width(line_words);
  endfunction

  localparam int IDX_W_DEFAULT = idx_width(LINE_WORDS_DEFAULT);
  localparam int TAG_W_DEFAULT = tag_width(LINE_WORDS_DEFAULT);

endpackage

// File: rtl/flash_prefetch_ctrl.sv
// Single-line prefetch buffer between a CPU read port and a flash burst engine.
// A miss launches one line-sized burst; words are served to the CPU as soon as
// they land, so a request for a word late in the line does not wait for the
// whole burst.
//
// Ports
//   clk, n_reset          clock, asynchronous active-low reset
//   req_valid/req_addr    CPU read request, held until req_ready
//   req_ready/req_rdata   one-cycle response pulse with its data
//   flush                 one-cycle pulse, invalidates the line
//   flash_start           one-cycle burst launch pulse
//   flash_address         line-aligned burst start address
//   flash_word_count      burst length, always LINE_WORDS
//   flash_strobe/_data    one burst word per strobe, ascending order
//   flash_done            one-cycle pulse after the last word
//   busy                  high while a burst is being launched or filled
module flash_prefetch_ctrl
  import flash_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT  // power of two, 2..16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req_valid,
  input  logic [23:0] req_addr,
  output logic        req_ready,
  output logic [31:0] req_rdata,
  input  logic        flush,
  output logic        flash_start,
  output logic [23:0] flash_address,
  output logic [23:0] flash_word_count,
  input  logic        flash_strobe,
  input  logic        flash_done,
  input  logic [31:0] flash_data,
  output logic        busy
);

  localparam int               IDX_W    = idx_width(LINE_WORDS);
  localparam int               TAG_W    = tag_width(LINE_WORDS);
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W + 1)'(LINE_WORDS);

  state_e                  state_q, state_d;
  logic [LINE_WORDS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic [IDX_W:0]          cnt_q, cnt_d;        // one extra bit: stops at LINE_WORDS
  logic                    discard_q, discard_d; // flush seen during a burst
  logic                    served_q, served_d;   // current request already answered
  logic                    req_ready_q, req_ready_d;
  logic [31:0]             req_rdata_q, req_rdata_d;
  logic                    flash_start_q, flash_start_d;
  logic [23:0]             flash_address_q, flash_address_d;
  logic                    busy_q, busy_d;

  logic [31:0]             data_q [LINE_WORDS];
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;

  logic [IDX_W-1:0]        req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    tag_hit;
  logic                    word_hit;
  logic                    unused_byte_offset;

  assign req_idx  = req_addr[IDX_W+1:2];
  assign req_tag  = req_addr[23:IDX_W+2];
  assign tag_hit  = (req_tag == tag_q);
  assign word_hit = tag_hit && valid_q[req_idx];

  // Reads are word-wide; the byte offset never selects anything.
  assign unused_byte_offset = ^req_addr[1:0];

  always_comb begin
    // NOTE: every _d starts from a default so no path through this block
    // leaves a variable unassigned and infers a latch.
    state_d         = state_q;
    valid_d         = valid_q;
    tag_d           = tag_q;
    cnt_d           = cnt_q;
    discard_d       = discard_q;
    req_ready_d     = 1'b0;
    req_rdata_d     = req_rdata_q;
    flash_start_d   = 1'b0;
    flash_address_d = flash_address_q;
    wr_en           = 1'b0;
    wr_idx          = cnt_q[IDX_W-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && !served_q) begin
          // A flush in the lookup cycle beats a hit: the line is refetched.
          if (word_hit && !flush) begin
            state_d     = ST_RESP;
            req_ready_d = 1'b1;
            req_rdata_d = data_q[req_idx];
          end else begin
            state_d         = ST_START;
            flash_start_d   = 1'b1;
            flash_address_d = {req_tag, {(IDX_W + 2){1'b0}}};
            tag_d           = req_tag;
            valid_d         = '0;
            cnt_d           = '0;
            discard_d       = 1'b0;
          end
        end else if (flush) begin
          valid_d = '0;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        if (flush) valid_d = '0;
      end

      ST_START: begin
        state_d = ST_FILL;
        if (flush) discard_d = 1'b1;
      end

      ST_FILL: begin
        // The burst is never aborted; a flush only poisons the line at the end.
        if (flush) discard_d = 1'b1;

        if (flash_strobe && (cnt_q < CNT_FULL)) begin
          wr_en          = 1'b1;
          valid_d[wr_idx] = 1'b1;
          cnt_d          = cnt_q + (IDX_W + 1)'(1);
        end

        // Same-line requests are answered from a landed word or straight from
        // the strobe that delivers it; other lines wait for the burst to end.
        if (req_valid && !served_q && tag_hit) begin
          if (valid_q[req_idx]) begin
            req_ready_d = 1'b1;
            req_rdata_d = data_q[req_idx];
          end else if (wr_en && (wr_idx == req_idx)) begin
            req_ready_d = 1'b1;
            req_rdata_d = flash_data;
          end
        end

        if (flash_done) begin
          state_d   = ST_IDLE;
          discard_d = 1'b0;
          if (discard_q || flush) valid_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Stays set from the response until the CPU drops req_valid.
    served_d = req_valid && (served_q || req_ready_d);
    busy_d   = (state_d == ST_START) || (state_d == ST_FILL);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q         <= ST_IDLE;
      valid_q         <= '0;
      tag_q           <= '0;
      cnt_q           <= '0;
      discard_q       <= 1'b0;
      served_q        <= 1'b0;
      req_ready_q     <= 1'b0;
      req_rdata_q     <= '0;
      flash_start_q   <= 1'b0;
      flash_address_q <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      cnt_q           <= cnt_d;
      discard_q       <= discard_d;
      served_q        <= served_d;
      req_ready_q     <= req_ready_d;
      req_rdata_q     <= req_rdata_d;
      flash_start_q   <= flash_start_d;
      flash_address_q <= flash_address_d;
      busy_q          <= busy_d;
    end
  end

  // NOTE: line data has no reset; the valid bits alone decide whether a word
  // may be used, so clearing the storage would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx] <= flash_data;
  end

  assign req_ready        = req_ready_q;
  assign req_rdata        = req_rdata_q;
  assign flash_start      = flash_start_q;
  assign flash_address    = flash_address_q;
  assign flash_word_count = 24'(LINE_WORDS);
  assign busy             = busy_q;

endmodule

// File: tb/tb_flash_prefetch_ctrl.sv
// Bench for flash_prefetch_ctrl: a cycle table for the cold-read/hit path,
// hand sequences for the multi-cycle corners, then randomized traffic checked
// against a line-level model of the buffer and a bench-side flash engine.
module tb_flash_prefetch_ctrl;

  localparam int LW = 4;

  logic        clk;
  logic        n_reset;
  logic        req_valid;
  logic [23:0] req_addr;
  logic        req_ready;
  logic [31:0] req_rdata;
  logic        flush;
  logic        flash_start;
  logic [23:0] flash_address;
  logic [23:0] flash_word_count;
  logic        flash_strobe;
  logic        flash_done;
  logic [31:0] flash_data;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  flash_prefetch_ctrl #(.LINE_WORDS(LW)) dut (
    .clk              (clk),
    .n_reset          (n_reset),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_ready        (req_ready),
    .req_rdata        (req_rdata),
    .flush            (flush),
    .flash_start      (flash_start),
    .flash_address    (flash_address),
    .flash_word_count (flash_word_count),
    .flash_strobe     (flash_strobe),
    .flash_done       (flash_done),
    .flash_data       (flash_data),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [23:0] addr;
    logic        fl;
    logic        st;
    logic        dn;
    logic [31:0] dat;
    logic        e_rdy;
    logic [31:0] e_rdata;
    logic        e_start;
    logic [23:0] e_faddr;
    logic        e_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [23:0] a, input logic fl,
                       input logic st, input logic dn, input logic [31:0] d);
    req_valid    = rv;
    req_addr     = a;
    flush        = fl;
    flash_strobe = st;
    flash_done   = dn;
    flash_data   = d;
  endtask

  task automatic idle_in();
    drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    idle_in();
    n_reset = 1'b0;
    repeat (2) cyc();
    #3 n_reset = 1'b1;
    cyc();
  endtask

  // Flash contents as seen by the random phase: a fixed function of address.
  function automatic logic [31:0] mem_word(input logic [23:0] a);
    logic [23:0] w;
    w = {a[23:2], 2'b00};
    return {w[15:0], ~w[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [23:0] line_base(input logic [23:0] a);
    return a & ~24'(LW * 4 - 1);
  endfunction

  // Random-phase state
  logic        eng_active;
  logic [23:0] eng_base;
  int          eng_next, eng_delay;
  logic        model_loaded;
  logic [23:0] model_base;
  logic        pend, pend_hit, hold;
  logic [23:0] pend_addr, pend_start_addr;
  int          pend_age, pend_starts, pend_exp_starts, gap;
  int          spurious, reissue, served_cnt;
  logic [23:0] bases[4];

  initial begin
    n_reset = 1'b0;
    idle_in();
    #2;
    // Reset state, checked while n_reset is still low.
    check("rst_req_ready", req_ready, 0);
    check("rst_req_rdata", req_rdata, 0);
    check("rst_flash_start", flash_start, 0);
    check("rst_flash_address", flash_address, 0);
    check("rst_busy", busy, 0);
    check("word_count", flash_word_count, LW);
    repeat (2) cyc();
    #3 n_reset = 1'b1;
    cyc();

    // Cold read of word 2, then a hit on word 3 of the same line.
    vecs[0] = '{1'b1, 24'h000008, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 24'h0, 1'b1};
    vecs[1] = '{1'b1, 24'h000008, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 24'h0, 1'b1};
    vecs[2] = '{1'b1, 24'h000008, 1'b0, 1'b1, 1'b0, 32'h11, 1'b0, 32'h0,  1'b0, 24'h0, 1'b1};
    vecs[3] = '{1'b1, 24'h000008, 1'b0, 1'b1, 1'b0, 32'h22, 1'b0, 32'h0,  1'b0, 24'h0, 1'b1};
    vecs[4] = '{1'b1, 24'h000008, 1'b0, 1'b1, 1'b0, 32'h33, 1'b1, 32'h33, 1'b0, 24'h0, 1'b1};
    vecs[5] = '{1'b1, 24'h000008, 1'b0, 1'b1, 1'b0, 32'h44, 1'b0, 32'h0,  1'b0, 24'h0, 1'b1};
    vecs[6] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0,  1'b0, 24'h0, 1'b0};
    vecs[7] = '{1'b1, 24'h00000C, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h44, 1'b0, 24'h0, 1'b0};
    vecs[8] = '{1'b1, 24'h00000C, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 24'h0, 1'b0};
    vecs[9] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 24'h0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rv, vecs[i].addr, vecs[i].fl, vecs[i].st, vecs[i].dn, vecs[i].dat);
      cyc();
      check($sformatf("vec%0d_ready", i), req_ready, vecs[i].e_rdy);
      if (vecs[i].e_rdy) check($sformatf("vec%0d_rdata", i), req_rdata, vecs[i].e_rdata);
      check($sformatf("vec%0d_start", i), flash_start, vecs[i].e_start);
      check($sformatf("vec%0d_faddr", i), flash_address, vecs[i].e_faddr);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
    end

    // Flush coincident with a hit lookup: treated as a miss.
    drive(1'b1, 24'h000000, 1'b1, 1'b0, 1'b0, 32'h0); cyc();
    check("flushhit_start", flash_start, 1);
    check("flushhit_addr", flash_address, 24'h000000);
    check("flushhit_ready", req_ready, 0);
    drive(1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 32'h0);   cyc();
    drive(1'b1, 24'h000000, 1'b0, 1'b1, 1'b0, 32'hA0);  cyc();
    check("w0_ready", req_ready, 1);
    check("w0_rdata", req_rdata, 32'hA0);
    drive(1'b1, 24'h000000, 1'b0, 1'b1, 1'b0, 32'hA1);  cyc();
    // Different-line request while the fill of line 0 continues.
    drive(1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 32'hA2);  cyc();
    drive(1'b1, 24'h000020, 1'b0, 1'b1, 1'b0, 32'hA3);  cyc();
    check("other_held_a", req_ready, 0);
    drive(1'b1, 24'h000020, 1'b0, 1'b0, 1'b0, 32'h0);   cyc();
    check("other_held_b", req_ready, 0);
    check("other_no_start", flash_start, 0);
    drive(1'b1, 24'h000020, 1'b0, 1'b0, 1'b1, 32'h0);   cyc();
    check("other_held_done", req_ready, 0);
    drive(1'b1, 24'h000020, 1'b0, 1'b0, 1'b0, 32'h0);   cyc();
    check("other_new_start", flash_start, 1);
    check("other_new_addr", flash_address, 24'h000020);
    drive(1'b1, 24'h000020, 1'b0, 1'b0, 1'b0, 32'h0);   cyc();
    drive(1'b1, 24'h000020, 1'b0, 1'b1, 1'b0, 32'hB0);  cyc();
    check("other_ready", req_ready, 1);
    check("other_rdata", req_rdata, 32'hB0);
    drive(1'b1, 24'h000020, 1'b0, 1'b1, 1'b0, 32'hB1);  cyc();
    drive(1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 32'hB2);  cyc();
    drive(1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 32'hB3);  cyc();
    drive(1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 32'h0);   cyc();
    check("other_idle_busy", busy, 0);

    // Flush mid-fill with a pending request for word 1.
    drive(1'b1, 24'h000004, 1'b0, 1'b0, 1'b0, 32'h0);   cyc();
    check("fl_start", flash_start, 1);
    check("fl_addr", flash_address, 24'h000000);
    drive(1'b1, 24'h000004, 1'b0, 1'b0, 1'b0, 32'h0);   cyc();
    drive(1'b1, 24'h000004, 1'b0, 1'b1, 1'b0, 32'h55);  cyc();
    check("fl_not_yet", req_ready, 0);
    drive(1'b1, 24'h000004, 1'b1, 1'b0, 1'b0, 32'h0);   cyc();
    check("fl_busy", busy, 1);
    drive(1'b1, 24'h000004, 1'b0, 1'b1, 1'b0, 32'h66);  cyc();
    check("fl_ready", req_ready, 1);
    check("fl_rdata", req_rdata, 32'h66);
    drive(1'b1, 24'h000004, 1'b0, 1'b1, 1'b0, 32'h77);  cyc();
    drive(1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 32'h88);  cyc();
    drive(1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 32'h0);   cyc();
    drive(1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 32'h0);   cyc();
    check("fl_refetch_start", flash_start, 1);
    check("fl_refetch_addr", flash_address, 24'h000000);

    // Reset after the second strobe of that burst.
    drive(1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 32'h0);   cyc();
    drive(1'b1, 24'h000000, 1'b0, 1'b1, 1'b0, 32'hC0);  cyc();
    drive(1'b1, 24'h000000, 1'b0, 1'b1, 1'b0, 32'hC1);  cyc();
    idle_in();
    n_reset = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_rdata", req_rdata, 0);
    check("mid_rst_start", flash_start, 0);
    check("mid_rst_faddr", flash_address, 0);
    check("mid_rst_busy", busy, 0);
    #3 n_reset = 1'b1;
    cyc();
    drive(1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 32'hDEAD); cyc();
    drive(1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 32'h0);    cyc();
    check("stale_busy", busy, 0);
    check("stale_ready", req_ready, 0);
    drive(1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 32'h0);    cyc();
    check("post_rst_start", flash_start, 1);
    check("post_rst_addr", flash_address, 24'h000000);

    // Randomized traffic against the line-level model.
    do_reset();
    bases[0] = 24'h000000; bases[1] = 24'h000010;
    bases[2] = 24'h000020; bases[3] = 24'h100030;
    eng_active = 1'b0; eng_base = '0; eng_next = 0; eng_delay = 0;
    model_loaded = 1'b0; model_base = '0;
    pend = 1'b0; pend_hit = 1'b0; hold = 1'b0; pend_addr = '0; pend_start_addr = '0;
    pend_age = 0; pend_starts = 0; pend_exp_starts = 0; gap = 1;
    spurious = 0; reissue = 0; served_cnt = 0;

    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (flash_start) begin
        if (eng_active) reissue++;
        eng_active = 1'b1;
        eng_base   = flash_address;
        eng_next   = 0;
        eng_delay  = $urandom_range(1, 3);
        if (pend) begin
          pend_starts++;
          pend_start_addr = flash_address;
        end
      end

      if (pend) begin
        pend_age++;
        if (pend_hit && pend_age == 1) check("rand_hit_latency", req_ready, 1);
        if (req_ready) begin
          check("rand_rdata", req_rdata, mem_word(pend_addr));
          check("rand_starts", pend_starts, pend_exp_starts);
          if (pend_exp_starts == 1)
            check("rand_start_addr", pend_start_addr, line_base(pend_addr));
          pend = 1'b0;
          hold = 1'b1;
          gap  = $urandom_range(1, 4);
          served_cnt++;
        end else if (pend_age > 100) begin
          check("rand_timeout", req_ready, 1);
          pend = 1'b0;
          gap  = 1;
        end
      end else if (req_ready) begin
        spurious++;
      end

      flash_strobe = 1'b0;
      flash_done   = 1'b0;
      if (eng_active) begin
        if (eng_delay > 0) begin
          eng_delay--;
        end else if (eng_next < LW) begin
          flash_strobe = 1'b1;
          flash_data   = mem_word(eng_base + 24'(4 * eng_next));
          eng_next++;
          eng_delay = $urandom_range(0, 2);
        end else begin
          flash_done   = 1'b1;
          eng_active   = 1'b0;
          model_base   = eng_base;
          model_loaded = 1'b1;
        end
      end

      flush = 1'b0;
      if (!pend && !hold && gap > 0 && !eng_active && $urandom_range(0, 15) == 0) begin
        flush        = 1'b1;
        model_loaded = 1'b0;
      end

      if (hold) begin
        hold = 1'b0;
      end else if (!pend) begin
        req_valid = 1'b0;
        if (gap > 0) begin
          gap--;
        end else begin
          pend_addr = bases[$urandom_range(0, 3)] + 24'(4 * $urandom_range(0, LW - 1))
                    + 24'($urandom_range(0, 3));
          pend       = 1'b1;
          pend_age   = 0;
          pend_starts = 0;
          pend_hit   = 1'b0;
          if (eng_active) begin
            pend_exp_starts = (line_base(eng_base) == line_base(pend_addr)) ? 0 : 1;
          end else if (model_loaded && model_base == line_base(pend_addr)) begin
            pend_hit        = 1'b1;
            pend_exp_starts = 0;
          end else begin
            pend_exp_starts = 1;
          end
          req_valid = 1'b1;
          req_addr  = pend_addr;
        end
      end
    end

    check("rand_no_spurious_ready", spurious, 0);
    check("rand_no_start_reissue", reissue, 0);
    check("rand_enough_traffic", served_cnt > 50, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
